// File: rtl/dmem_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// State and owner encodings are fixed so that waveforms and debug tooling can decode them.
package dmem_arb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  // An address is out of range when any bit above the memory's byte-address width is set.
  function automatic logic addr_oor(input logic [WORD_W-1:0] a, input int unsigned aw);
    return (a >> aw) != '0;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals around the data-memory arbiter.
// slave = the arbiter's view, master = the surrounding environment's view.
interface dmem_access_arbiter_if #(
  parameter int ADDR_W = 7
);
  import dmem_arb_pkg::*;

  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [WORD_W-1:0] cpu_addr_i;
  logic [WORD_W-1:0] cpu_wdata_i;
  logic [WORD_W-1:0] cpu_rdata_o;
  logic              cpu_ack_o;
  logic              cpu_stall_o;

  logic              dbg_req_i;
  logic              dbg_we_i;
  logic [WORD_W-1:0] dbg_addr_i;
  logic [WORD_W-1:0] dbg_wdata_i;
  logic [WORD_W-1:0] dbg_rdata_o;
  logic              dbg_ack_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [WORD_W-1:0] mem_wdata_o;
  logic [WORD_W-1:0] mem_rdata_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_rdata_o, dbg_ack_o,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_rdata_o, dbg_ack_o,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/dmem_access_arbiter_prio.sv
// Two-way CPU/debug priority pick with a starvation counter that forces a debug win
// after STARVE_MAX consecutive CPU grants taken while debug was waiting.
module dmem_prio_arb
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   arb_en_i,
  input  logic   cpu_req_i,
  input  logic   dbg_req_i,
  output logic   gnt_vld_o,
  output owner_e gnt_own_o
);

  localparam int SC_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

  logic [SC_W-1:0] starve_q, starve_d;
  logic            dbg_win;

  assign dbg_win   = dbg_req_i & (~cpu_req_i | (starve_q == SC_MAX));
  assign gnt_vld_o = cpu_req_i | dbg_req_i;

  always_comb begin
    gnt_own_o = OWN_CPU;
    if (dbg_win) gnt_own_o = OWN_DBG;
  end

  // Only IDLE cycles count; the counter is frozen while a transaction is in flight.
  always_comb begin
    starve_d = starve_q;
    if (arb_en_i) begin
      if (!dbg_req_i || dbg_win)  starve_d = '0;
      else if (starve_q != SC_MAX) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= '0;
    else       starve_q <= starve_d;
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Data-memory access sequencer shared by the MEM stage and the debug/loader port.
// IDLE -> ACCESS (LATENCY cycles) -> DONE (one-cycle ack) -> IDLE.
module dmem_access_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dmem_access_arbiter_if.slave  bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  owner_e            owner_q;
  logic              we_q;
  logic              oor_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic              cpu_ack_q, dbg_ack_q;

  logic              arb_en;
  logic              gnt_vld;
  owner_e            gnt_own;
  dmem_req_t         cpu_rq, dbg_rq, sel_rq;
  logic [WORD_W-1:0] rd_cap;
  logic              in_acc;

  assign arb_en = (state_q == ST_IDLE);

  dmem_prio_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arb_en_i  (arb_en),
    .cpu_req_i (bus.cpu_req_i),
    .dbg_req_i (bus.dbg_req_i),
    .gnt_vld_o (gnt_vld),
    .gnt_own_o (gnt_own)
  );

  always_comb begin
    cpu_rq = '{we: bus.cpu_we_i, addr: bus.cpu_addr_i, wdata: bus.cpu_wdata_i};
    dbg_rq = '{we: bus.dbg_we_i, addr: bus.dbg_addr_i, wdata: bus.dbg_wdata_i};
    sel_rq = (gnt_own == OWN_DBG) ? dbg_rq : cpu_rq;
    // Out-of-range reads return zero regardless of what the macro presents.
    rd_cap = oor_q ? '0 : bus.mem_rdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      oor_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      cpu_ack_q <= 1'b0;
      dbg_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_vld) begin
            owner_q <= gnt_own;
            we_q    <= sel_rq.we;
            oor_q   <= addr_oor(sel_rq.addr, ADDR_W);
            addr_q  <= {sel_rq.addr[ADDR_W-1:2], 2'b00};
            wdata_q <= sel_rq.wdata;
            cnt_q   <= CNT_INIT;
            state_q <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (owner_q == OWN_DBG) begin
              dbg_rdata_q <= rd_cap;
              dbg_ack_q   <= 1'b1;
            end else begin
              cpu_rdata_q <= rd_cap;
              cpu_ack_q   <= 1'b1;
            end
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Memory-side outputs are decoded from registered state; the write strobe is the final access cycle only.
  assign in_acc          = (state_q == ST_ACCESS) & ~oor_q;
  assign bus.mem_en_o    = in_acc;
  assign bus.mem_we_o    = in_acc & we_q & (cnt_q == '0);
  assign bus.mem_addr_o  = in_acc ? addr_q : '0;
  assign bus.mem_wdata_o = in_acc ? wdata_q : '0;

  assign bus.cpu_ack_o   = cpu_ack_q;
  assign bus.dbg_ack_o   = dbg_ack_q;
  assign bus.cpu_rdata_o = cpu_rdata_q;
  assign bus.dbg_rdata_o = dbg_rdata_q;
  assign bus.cpu_stall_o = bus.cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: LATENCY=2 instance for the main tests, LATENCY=1 instance for the sweep.
module tb_dmem_access_arbiter;
  import dmem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  dmem_access_arbiter_if #(.ADDR_W(7)) b2 ();
  dmem_access_arbiter_if #(.ADDR_W(7)) b1 ();

  dmem_access_arbiter #(.ADDR_W(7), .LATENCY(2), .STARVE_MAX(4)) u2 (
    .clk_i(clk), .rst_i(rst), .bus(b2));
  dmem_access_arbiter #(.ADDR_W(7), .LATENCY(1), .STARVE_MAX(4)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(b1));

  // Behavioural data memories
  logic [31:0] mem2 [32];
  logic [31:0] mem1 [32];
  assign b2.mem_rdata_i = mem2[b2.mem_addr_o[6:2]];
  assign b1.mem_rdata_i = mem1[b1.mem_addr_o[6:2]];
  always @(posedge clk) begin
    if (b2.mem_we_o) mem2[b2.mem_addr_o[6:2]] = b2.mem_wdata_o;
    if (b1.mem_we_o) mem1[b1.mem_addr_o[6:2]] = b1.mem_wdata_o;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectations pushed on drive, popped on ack
  typedef struct {
    logic        rd;
    logic [31:0] data;
  } exp_t;
  exp_t cq2[$], dq2[$], cq1[$];
  exp_t em;
  int we_cnt2  = 0;
  int ack_cnt2 = 0;

  always @(negedge clk) begin
    if (b2.mem_we_o) we_cnt2++;
    if (b2.cpu_ack_o || b2.dbg_ack_o) ack_cnt2++;
    if (b2.cpu_ack_o) begin
      if (cq2.size() == 0) chk("u2_cpu_unexpected_ack", 1, 0);
      else begin
        em = cq2.pop_front();
        if (em.rd) chk("u2_cpu_rdata", b2.cpu_rdata_o, em.data);
      end
    end
    if (b2.dbg_ack_o) begin
      if (dq2.size() == 0) chk("u2_dbg_unexpected_ack", 1, 0);
      else begin
        em = dq2.pop_front();
        if (em.rd) chk("u2_dbg_rdata", b2.dbg_rdata_o, em.data);
      end
    end
    if (b1.cpu_ack_o) begin
      if (cq1.size() == 0) chk("u1_cpu_unexpected_ack", 1, 0);
      else begin
        em = cq1.pop_front();
        if (em.rd) chk("u1_cpu_rdata", b1.cpu_rdata_o, em.data);
      end
    end
  end

  function automatic logic [127:0] outs2();
    return {21'b0, b2.cpu_ack_o, b2.dbg_ack_o, b2.mem_en_o, b2.mem_we_o, b2.mem_addr_o,
            b2.mem_wdata_o, b2.cpu_rdata_o, b2.dbg_rdata_o};
  endfunction

  // One complete access on u2; caller is at posedge+1. Returns ack latency in cycles and mem_en activity.
  task automatic access2(input logic dbg, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp,
                         output int lat, output logic en_seen);
    exp_t e;
    logic ack;
    e.rd = ~we; e.data = exp;
    if (dbg) begin
      dq2.push_back(e);
      b2.dbg_we_i = we; b2.dbg_addr_i = addr; b2.dbg_wdata_i = wdata; b2.dbg_req_i = 1'b1;
    end else begin
      cq2.push_back(e);
      b2.cpu_we_i = we; b2.cpu_addr_i = addr; b2.cpu_wdata_i = wdata; b2.cpu_req_i = 1'b1;
    end
    lat = -1; en_seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b2.mem_en_o) en_seen = 1'b1;
      ack = dbg ? b2.dbg_ack_o : b2.cpu_ack_o;
      if (ack) begin lat = n; break; end
    end
    @(posedge clk); #1;
    b2.cpu_req_i = 1'b0;
    b2.dbg_req_i = 1'b0;
  endtask

  typedef struct {
    logic        dbg;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_en;
  } vec_t;
  vec_t vecs[12];

  logic [3:0]  e_en, e_st, e_ack, e_we;
  logic [5:0]  ord;
  int          lat, nacks, last_ack, t0;
  logic        en_seen;
  int          we0, a0;

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem2[i] = 32'hA500_0000 + i;
      mem1[i] = 32'h1100_0000 + i;
    end
    mem2[2] = 32'hDEAD_BEEF;
    {b2.cpu_req_i, b2.cpu_we_i, b2.dbg_req_i, b2.dbg_we_i} = '0;
    {b2.cpu_addr_i, b2.cpu_wdata_i, b2.dbg_addr_i, b2.dbg_wdata_i} = '0;
    {b1.cpu_req_i, b1.cpu_we_i, b1.dbg_req_i, b1.dbg_we_i} = '0;
    {b1.cpu_addr_i, b1.cpu_wdata_i, b1.dbg_addr_i, b1.dbg_wdata_i} = '0;

    //                dbg   we    addr           wdata          exp_rdata      en
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_0001, 32'h0,         1'b1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         32'h1111_0001, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 32'h0000_0014, 32'h2222_0002, 32'h0,         1'b1};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0017, 32'h0,         32'h2222_0002, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 32'h0000_0013, 32'h0,         32'h1111_0001, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_007C, 32'h7C7C_7C7C, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_007C, 32'h0,         32'h7C7C_7C7C, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0080, 32'hDEAD_0080, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA500_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h0,         1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         32'hA500_0008, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", outs2(), 0);
    chk("reset_stall", b2.cpu_stall_o, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Reset in the middle of a store aborts it
    we0 = we_cnt2; a0 = ack_cnt2;
    b2.cpu_we_i = 1'b1; b2.cpu_addr_i = 32'h20; b2.cpu_wdata_i = 32'hCAFE_F00D; b2.cpu_req_i = 1'b1;
    @(posedge clk); #1 rst = 1'b1; b2.cpu_req_i = 1'b0;
    @(posedge clk); #1 b2.cpu_req_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", outs2(), 0);
    chk("rst_mid_stall_follows_req", b2.cpu_stall_o, 1);
    @(posedge clk); #1 b2.cpu_req_i = 1'b0; b2.cpu_we_i = 1'b0; rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_abort_no_we", we_cnt2, we0);
    chk("rst_abort_no_ack", ack_cnt2, a0);
    chk("rst_abort_mem_untouched", mem2[8], 32'hA500_0008);
    @(posedge clk); #1;

    // CPU load at 0x8: cycle-by-cycle timing
    e_en = 4'b0110; e_st = 4'b0111; e_ack = 4'b1000;
    cq2.push_back('{1'b1, 32'hDEAD_BEEF});
    b2.cpu_we_i = 1'b0; b2.cpu_addr_i = 32'h8; b2.cpu_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("load_en_T%0d", k), b2.mem_en_o, e_en[k]);
      chk($sformatf("load_stall_T%0d", k), b2.cpu_stall_o, e_st[k]);
      chk($sformatf("load_ack_T%0d", k), b2.cpu_ack_o, e_ack[k]);
    end
    @(posedge clk); #1 b2.cpu_req_i = 1'b0;

    // CPU store at 0x0D: aligned address and single write strobe
    e_we = 4'b0100;
    cq2.push_back('{1'b0, 32'h0});
    b2.cpu_we_i = 1'b1; b2.cpu_addr_i = 32'h0D; b2.cpu_wdata_i = 32'h1234_5678; b2.cpu_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("store_we_T%0d", k), b2.mem_we_o, e_we[k]);
      if (k == 1 || k == 2) begin
        chk($sformatf("store_addr_T%0d", k), b2.mem_addr_o, 7'h0C);
        chk($sformatf("store_wdata_T%0d", k), b2.mem_wdata_o, 32'h1234_5678);
      end
      if (k == 3) chk("store_ack", b2.cpu_ack_o, 1);
    end
    @(posedge clk); #1 b2.cpu_req_i = 1'b0; b2.cpu_we_i = 1'b0;
    chk("store_mem_word3", mem2[3], 32'h1234_5678);

    // Table of single accesses
    for (int i = 0; i < 12; i++) begin
      access2(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, lat, en_seen);
      chk($sformatf("vec%0d_latency", i), lat, 3);
      chk($sformatf("vec%0d_mem_en", i), en_seen, vecs[i].exp_en);
    end

    // Both ports requesting continuously: dbg forced in on the 5th grant
    for (int i = 0; i < 5; i++) cq2.push_back('{1'b1, 32'hA500_0001});
    dq2.push_back('{1'b1, 32'hDEAD_BEEF});
    b2.cpu_we_i = 1'b0; b2.cpu_addr_i = 32'h4; b2.cpu_req_i = 1'b1;
    b2.dbg_we_i = 1'b0; b2.dbg_addr_i = 32'h8; b2.dbg_req_i = 1'b1;
    nacks = 0; ord = '0;
    for (int n = 0; n < 80 && nacks < 6; n++) begin
      @(negedge clk);
      if (b2.cpu_ack_o || b2.dbg_ack_o) begin
        ord[nacks] = b2.dbg_ack_o;
        nacks++;
      end
    end
    @(posedge clk); #1 b2.cpu_req_i = 1'b0; b2.dbg_req_i = 1'b0;
    chk("starve_ack_count", nacks, 6);
    chk("starve_grant_order", ord, 6'b010000);

    // LATENCY=1 back-to-back CPU loads
    for (int i = 0; i < 4; i++) cq1.push_back('{1'b1, 32'h1100_0000 + i});
    b1.cpu_we_i = 1'b0; b1.cpu_addr_i = 32'h0; b1.cpu_req_i = 1'b1;
    t0 = cyc; last_ack = 0;
    for (int i = 0; i < 4; i++) begin
      nacks = 0;
      for (int n = 0; n < 10 && nacks == 0; n++) begin
        @(negedge clk);
        if (b1.cpu_ack_o) nacks = 1;
      end
      chk($sformatf("lat1_ack%0d_seen", i), nacks, 1);
      if (i == 0) chk("lat1_first_latency", cyc - t0, 2);
      else        chk($sformatf("lat1_spacing%0d", i), cyc - last_ack, 3);
      last_ack = cyc;
      @(posedge clk); #1;
      if (i < 3) b1.cpu_addr_i = 32'(4 * (i + 1));
      else       b1.cpu_req_i = 1'b0;
    end

    repeat (4) @(negedge clk);
    chk("sb_u2_cpu_drained", cq2.size(), 0);
    chk("sb_u2_dbg_drained", dq2.size(), 0);
    chk("sb_u1_cpu_drained", cq1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
